// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin result-bus arbiter.
package arb_pkg;

  localparam int N_REQ  = 8;
  localparam int SEL_W  = 3;
  localparam int DW_DEF = 32;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] onehot(input sel_t idx);
    logic [N_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority picker: first requester after ptr wins,
// scanning ptr+1 .. ptr+8 modulo 8.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] win,
  output logic             any
);

  // NOTE: every variable in always_comb gets a default before any branch,
  // otherwise a missing assignment path infers a latch.
  always_comb begin
    win = ptr;
    // Walk from the farthest slot back to the nearest so the nearest hit is
    // the last assignment and therefore the winner.
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[ptr + sel_t'(k)]) win = ptr + sel_t'(k);
    end
    any = |req;
  end

endmodule

// File: rtl/rr_bus_arbiter8.sv
// Round-robin arbiter sharing one DW-bit result bus among 8 requesters, with a
// registered valid/ready output stage. Optional bus lock under `ARB_LOCK_EN.
module rr_bus_arbiter8
  import arb_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] din,
  input  logic [N_REQ-1:0]    lock,
  output logic [N_REQ-1:0]    ack,
  output logic [DW-1:0]       out_data,
  output logic [SEL_W-1:0]    out_src,
  output logic                out_valid,
  input  logic                out_ready
);

  state_e        state;
  sel_t          ptr;
  sel_t          rr_win;
  sel_t          win;
  logic          any;
  logic          can_load;
  logic          load;
  logic [DW-1:0] words [N_REQ];

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr),
    .win (rr_win),
    .any (any)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) words[i] = din[i*DW +: DW];
  end

  // A slot opens when the register is empty or its word leaves this cycle;
  // reset suppresses capture so ack stays low while rst is high.
  assign can_load = !rst && (state == ST_EMPTY || out_ready);
  assign load     = can_load && any;
  assign ack      = load ? onehot(win) : '0;

`ifdef ARB_LOCK_EN
  logic lock_hold;
  sel_t hold_idx;
  logic hold_hit;

  assign hold_hit = lock_hold && req[hold_idx];
  assign win      = hold_hit ? hold_idx : rr_win;

  // A holder that withdraws its request at a load opportunity gives up the
  // bus even if nobody else is requesting.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_hold <= 1'b0;
      hold_idx  <= '0;
    end else if (load) begin
      lock_hold <= lock[win];
      hold_idx  <= win;
    end else if (can_load && lock_hold && !req[hold_idx]) begin
      lock_hold <= 1'b0;
    end
  end
`else
  logic unused_lock;

  assign win         = rr_win;
  assign unused_lock = ^lock;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= sel_t'(N_REQ - 1);
    end else begin
      case (state)
        ST_EMPTY: begin
          if (load) begin
            state     <= ST_FULL;
            out_valid <= 1'b1;
            out_data  <= words[win];
            out_src   <= win;
            ptr       <= win;
          end
        end
        ST_FULL: begin
          if (load) begin
            // Back-to-back beat: the departing word is replaced in place.
            out_data <= words[win];
            out_src  <= win;
            ptr      <= win;
          end else if (out_ready) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter8.sv
// Directed bench for rr_bus_arbiter8: driver checks ack and hold behaviour,
// a monitor compares each accepted output beat against a scoreboard queue.
module tb_rr_bus_arbiter8;

  localparam int DW = 32;

  typedef struct packed {
    logic [2:0]    src;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [7:0]    req;
  logic [8*DW-1:0] din;
  logic [7:0]    lock;
  logic [7:0]    ack;
  logic [DW-1:0] out_data;
  logic [2:0]    out_src;
  logic          out_valid;
  logic          out_ready;

  logic [DW-1:0] words [8];
  exp_t          sb [$];
  int            tests;
  int            fails;

  rr_bus_arbiter8 #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .lock      (lock),
    .ack       (ack),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 8; i++) din[i*DW +: DW] = words[i];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] base_word(input int i);
    return 32'hA500_0000 | DW'(i);
  endfunction

  // Inputs change 1 time unit after the rising edge; sampling is on the falling edge.
  task automatic step(input logic [7:0] r, input logic rdy, input logic [7:0] lk, input logic rs);
    @(posedge clk);
    #1;
    req       = r;
    out_ready = rdy;
    lock      = lk;
    rst       = rs;
    @(negedge clk);
  endtask

  task automatic expect_load(input string name, input int src);
    exp_t e;
    check(name, ack, 8'b1 << src);
    e.src  = 3'(src);
    e.data = words[src];
    sb.push_back(e);
  endtask

  // Monitor: every accepted beat must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_src", out_src, e.src);
        check("out_data", out_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] lock_seq [4];
    int         lock_exp [4];

    tests = 0;
    fails = 0;
    for (int i = 0; i < 8; i++) words[i] = base_word(i);
    rst       = 1'b1;
    req       = 8'hFF;
    lock      = 8'h00;
    out_ready = 1'b1;

    // Reset held with all requesters active
    repeat (2) begin
      step(8'hFF, 1'b1, 8'h00, 1'b1);
      check("rst_ack", ack, 8'h00);
      check("rst_valid", out_valid, 1'b0);
      check("rst_data", out_data, 32'h0);
    end

    // Rotation: 0..7 then wrap to 0, first ack after release is requester 0
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 1'b1, 8'h00, 1'b0);
      expect_load("rot_ack", i % 8);
    end

    // Single requester
    words[3] = 32'hDEAD_BEEF;
    step(8'h08, 1'b1, 8'h00, 1'b0);
    expect_load("single_ack", 3);
    step(8'h00, 1'b1, 8'h00, 1'b0);
    check("single_idle_ack", ack, 8'h00);
    check("single_valid", out_valid, 1'b1);
    step(8'h00, 1'b1, 8'h00, 1'b0);
    check("drain_valid", out_valid, 1'b0);
    words[3] = base_word(3);

    // Backpressure: full with src 1, sink stalls for 5 cycles
    step(8'h02, 1'b1, 8'h00, 1'b0);
    expect_load("bp_load_ack", 1);
    repeat (5) begin
      step(8'h06, 1'b0, 8'h00, 1'b0);
      check("bp_ack", ack, 8'h00);
      check("bp_valid", out_valid, 1'b1);
      check("bp_src", out_src, 3'd1);
      check("bp_data", out_data, base_word(1));
    end
    step(8'h06, 1'b1, 8'h00, 1'b0);
    expect_load("bp_release_ack", 2);
    step(8'h00, 1'b1, 8'h00, 1'b0);
    step(8'h00, 1'b1, 8'h00, 1'b0);
    check("bp_drain_valid", out_valid, 1'b0);

    // Park the pointer at 7 so requester 2 wins the first lock-test round
    step(8'h80, 1'b1, 8'h00, 1'b0);
    expect_load("park_ack", 7);

    lock_seq = '{8'h04, 8'h04, 8'h00, 8'h00};
`ifdef ARB_LOCK_EN
    lock_exp = '{2, 2, 2, 5};
`else
    lock_exp = '{2, 5, 2, 5};
`endif
    for (int k = 0; k < 4; k++) begin
      step(8'h24, 1'b1, lock_seq[k], 1'b0);
      expect_load("lock_ack", lock_exp[k]);
    end
    step(8'h00, 1'b1, 8'h00, 1'b0);

    // Mid-operation reset: captured src 6 word is discarded, pointer returns to 7
    step(8'h40, 1'b1, 8'h00, 1'b0);
    check("mid_load_ack", ack, 8'h40);
    step(8'h41, 1'b0, 8'h00, 1'b1);
    check("mid_rst_ack", ack, 8'h00);
    check("mid_rst_full", out_valid, 1'b1);
    check("mid_rst_src", out_src, 3'd6);
    step(8'h41, 1'b1, 8'h00, 1'b0);
    check("mid_after_valid", out_valid, 1'b0);
    expect_load("mid_after_ack", 0);
    step(8'h00, 1'b1, 8'h00, 1'b0);
    step(8'h00, 1'b1, 8'h00, 1'b0);
    check("final_valid", out_valid, 1'b0);

    check("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
